move_scheduler_2048: RTL

//  Sits between the four direction buttons and the 4x4 board datapath of the 2048 game.

---
 rtl/move_scheduler_2048.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/move_scheduler_2048.sv
// move_scheduler_2048
//   Turns the four raw direction buttons of the 2048 game into single move
//   commands. It then walks the external line-merge unit over every board line
//   and asks for a tile spawn when at least one line changed.
//
//   Optional feature macro: MOVE_SCHED_TIMEOUT_EN. When it is defined, each line
//   has a watchdog of TIMEOUT_CYC cycles. When it expires, the move is aborted
//   and err is set and stays set.
//
//   Ports:
//     Clk, Reset            game clock, synchronous active-high reset
//     BtnU/BtnD/BtnL/BtnR   raw buttons (asynchronous, bouncy)
//     halt                  game over; new presses are ignored
//     line_start            1-cycle pulse: process line_idx in direction line_dir
//     line_idx, line_dir    current line and direction (00 U, 01 D, 10 L, 11 R)
//     line_done             line unit finished; line_changed qualifies it
//     spawn_req/spawn_ack   tile spawn handshake
//     busy                  high whenever a move is in progress
//     move_done, moved      end-of-move pulse and "board changed" result
//     err                   sticky timeout flag
module move_scheduler_2048 #(
  parameter int N_LINES     = 4,
  parameter int DEB_CYCLES  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       BtnU,
  input  logic                       BtnD,
  input  logic                       BtnL,
  input  logic                       BtnR,
  input  logic                       halt,
  output logic                       line_start,
  output logic [$clog2(N_LINES)-1:0] line_idx,
  output logic [1:0]                 line_dir,
  input  logic                       line_done,
  input  logic                       line_changed,
  output logic                       spawn_req,
  input  logic                       spawn_ack,
  output logic                       busy,
  output logic                       move_done,
  output logic                       moved,
  output logic                       err
);

  localparam int IW = $clog2(N_LINES);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_LINES - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_LINE = 3'd2,
    S_NEXT      = 3'd3,
    S_SPAWN     = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  // Bit order everywhere: [3]=U, [2]=D, [1]=L, [0]=R
  logic [3:0]    btn_raw_s;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    deb_q, deb_d, deb_prev_q;
  logic [DW-1:0] cnt_q [4];
  logic [DW-1:0] cnt_d [4];
  logic [3:0]    evt_s;
  logic          sel_valid_s;
  logic [1:0]    sel_dir_s;

  state_e        state_q;
  logic          line_start_q, spawn_req_q, busy_q, move_done_q, moved_q;
  logic [IW-1:0] line_idx_q;
  logic [1:0]    line_dir_q;
  logic          any_changed_q;

  assign btn_raw_s = {BtnU, BtnD, BtnL, BtnR};

  // Two-flop synchronisers, debounce counters and debounced-level history
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q    <= 4'b0000;
      sync2_q    <= 4'b0000;
      deb_q      <= 4'b0000;
      deb_prev_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= btn_raw_s;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // The counter runs only while the synced level disagrees with the accepted
  // level. Any bounce back to the accepted level restarts it.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  assign evt_s = deb_q & ~deb_prev_q;

  // Fixed-priority pick among press events of the same cycle
  always_comb begin
    sel_valid_s = 1'b1;
    sel_dir_s   = 2'b00;
    if (evt_s[3]) begin
      sel_dir_s = 2'b00;
    end else if (evt_s[2]) begin
      sel_dir_s = 2'b01;
    end else if (evt_s[1]) begin
      sel_dir_s = 2'b10;
    end else if (evt_s[0]) begin
      sel_dir_s = 2'b11;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

`ifdef MOVE_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;
  assign err = err_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYC > 0);
  assign err = 1'b0;
`endif

  // Move sequencer; every output is registered here
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      line_start_q  <= 1'b0;
      line_idx_q    <= '0;
      line_dir_q    <= 2'b00;
      spawn_req_q   <= 1'b0;
      busy_q        <= 1'b0;
      move_done_q   <= 1'b0;
      moved_q       <= 1'b0;
      any_changed_q <= 1'b0;
`ifdef MOVE_SCHED_TIMEOUT_EN
      tmo_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_valid_s && !halt) begin
            state_q       <= S_ISSUE;
            line_dir_q    <= sel_dir_s;
            line_idx_q    <= '0;
            any_changed_q <= 1'b0;
            line_start_q  <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        S_ISSUE: begin
          line_start_q <= 1'b0;
          state_q      <= S_WAIT_LINE;
`ifdef MOVE_SCHED_TIMEOUT_EN
          tmo_q        <= '0;
`endif
        end
        S_WAIT_LINE: begin
          if (line_done) begin
            any_changed_q <= any_changed_q | line_changed;
            if (line_idx_q == LAST_IDX) begin
              // The last line's own change counts toward the spawn decision
              if (any_changed_q | line_changed) begin
                state_q     <= S_SPAWN;
                spawn_req_q <= 1'b1;
              end else begin
                state_q     <= S_DONE;
                move_done_q <= 1'b1;
                moved_q     <= 1'b0;
              end
            end else begin
              state_q <= S_NEXT;
            end
          end
`ifdef MOVE_SCHED_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q     <= S_DONE;
            move_done_q <= 1'b1;
            moved_q     <= 1'b0;
            err_q       <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
        S_NEXT: begin
          line_idx_q   <= line_idx_q + IW'(1);
          line_start_q <= 1'b1;
          state_q      <= S_ISSUE;
        end
        S_SPAWN: begin
          if (spawn_ack) begin
            spawn_req_q <= 1'b0;
            state_q     <= S_DONE;
            move_done_q <= 1'b1;
            moved_q     <= any_changed_q;
          end
        end
        S_DONE: begin
          move_done_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q      <= S_IDLE;
          line_start_q <= 1'b0;
          spawn_req_q  <= 1'b0;
          busy_q       <= 1'b0;
          move_done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign line_start = line_start_q;
  assign line_idx   = line_idx_q;
  assign line_dir   = line_dir_q;
  assign spawn_req  = spawn_req_q;
  assign busy       = busy_q;
  assign move_done  = move_done_q;
  assign moved      = moved_q;

endmodule
